// File: rtl/instr_cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package instr_cache_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int INDEX_W = 6;
    localparam int OFF_W   = 2;
    localparam int TAG_W   = ADDR_W - INDEX_W - OFF_W;
    localparam int LINES   = 2 ** INDEX_W;
    localparam int WORDS   = 2 ** OFF_W;

    localparam logic [DATA_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [INDEX_W-1:0] idx_t;
    typedef logic [OFF_W-1:0]   off_t;

    function automatic tag_t addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic idx_t addr_idx(input logic [ADDR_W-1:0] a);
        return a[OFF_W +: INDEX_W];
    endfunction

    function automatic off_t addr_off(input logic [ADDR_W-1:0] a);
        return a[OFF_W-1:0];
    endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Tag, data and valid storage: one async read port, one sync write port,
// plus a global valid clear. Only the valid vector is reset.
module icache_array
    import instr_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  idx_t              rd_idx,
    input  off_t              rd_off,
    output logic              rd_valid,
    output tag_t              rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  idx_t              wr_idx,
    input  off_t              wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  tag_t              wr_tag,
    input  logic              set_valid,
    input  logic              inval
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    tag_t              tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES*WORDS];

    // A global clear overrides a line being set in the same cycle.
    always_comb begin
        valid_d = valid_q;
        if (set_valid) valid_d[wr_idx] = 1'b1;
        if (inval)     valid_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en)  data_arr[{wr_idx, wr_off}] <= wr_data;
        if (tag_we) tag_arr[wr_idx]            <= wr_tag;
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_arr[rd_idx];
    assign rd_data  = data_arr[{rd_idx, rd_off}];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path,
// blocking word-serial line refill on a miss.
module instr_cache
    import instr_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] instr,
    output logic              i_hit,
    input  logic              inval,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_valid
);

    state_e            state_q, state_d;
    off_t              beat_q, beat_d;
    logic [ADDR_W-1:0] miss_addr_q, miss_addr_d;
    logic              kill_q, kill_d;

    logic              rd_valid;
    tag_t              rd_tag;
    logic [DATA_W-1:0] rd_data;
    logic              lookup_hit;
    logic              last_beat;
    logic              wr_en;
    logic              tag_we;
    logic              set_valid;

    assign lookup_hit = rd_valid && (rd_tag == addr_tag(i_addr));
    assign last_beat  = (state_q == ST_FILL) && mem_valid
                        && (beat_q == off_t'(WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            miss_addr_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            miss_addr_q <= miss_addr_d;
            kill_q      <= kill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        miss_addr_d = miss_addr_q;
        kill_d      = kill_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!lookup_hit) begin
                    state_d     = ST_FILL;
                    miss_addr_d = {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    beat_d      = '0;
                    kill_d      = 1'b0;
                end
            end
            ST_FILL: begin
                // An invalidate seen mid-refill poisons the pending line.
                if (inval) kill_d = 1'b1;
                if (mem_valid) begin
                    if (beat_q == off_t'(WORDS - 1)) state_d = ST_DONE;
                    else beat_d = beat_q + off_t'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        i_hit     = lookup_hit && (state_q == ST_IDLE);
        instr     = i_hit ? rd_data : NOP;
        mem_re    = (state_q == ST_FILL);
        mem_addr  = miss_addr_q;
        wr_en     = (state_q == ST_FILL) && mem_valid;
        tag_we    = last_beat;
        set_valid = last_beat && !inval && !kill_q;
    end

    icache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (addr_idx(i_addr)),
        .rd_off    (addr_off(i_addr)),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (addr_idx(miss_addr_q)),
        .wr_off    (beat_q),
        .wr_data   (mem_rd_data),
        .tag_we    (tag_we),
        .wr_tag    (addr_tag(miss_addr_q)),
        .set_valid (set_valid),
        .inval     (inval)
    );

endmodule

// File: tb/tb_instr_cache.sv
// Directed scoreboard bench for instr_cache: refill, hit path, conflicts,
// redirect, invalidate and reset cases.
module tb_instr_cache;

    logic        clk;
    logic        rst;
    logic [15:0] i_addr;
    logic [15:0] instr;
    logic        i_hit;
    logic        inval;
    logic        mem_re;
    logic [15:0] mem_addr;
    logic [15:0] mem_rd_data;
    logic        mem_valid;

    int          total;
    int          bad;
    logic [15:0] sb[$];

    instr_cache dut (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (i_addr),
        .instr       (instr),
        .i_hit       (i_hit),
        .inval       (inval),
        .mem_re      (mem_re),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_valid   (mem_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hB700 ^ {a[7:0], 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_re(input logic [15:0] base);
        int n = 0;
        while (mem_re !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("mem_re", {31'd0, mem_re}, 32'd1);
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, base});
    endtask

    // pat bit i = beat offered in cycle i; redirect/inval keyed by beat number
    task automatic feed(input logic [15:0] base, input logic [7:0] pat,
                        input int len, input int redir_at,
                        input logic [15:0] redir_addr, input int inval_at);
        int b = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            mem_valid   = pat[i];
            mem_rd_data = pat[i] ? mem_word(base + 16'(b)) : 16'hDEAD;
            inval       = pat[i] && (b == inval_at);
            if (pat[i] && b == redir_at) i_addr = redir_addr;
            if (pat[i]) b++;
            #1;
            chk("blocked", {31'd0, i_hit}, 32'd0);
        end
        @(negedge clk);
        mem_valid   = 1'b0;
        inval       = 1'b0;
        mem_rd_data = 16'h0000;
        #1;
        chk("done_nohit", {31'd0, i_hit}, 32'd0);
    endtask

    task automatic wait_hit(input logic [15:0] exp);
        int n = 0;
        logic [15:0] e;
        sb.push_back(exp);
        while (i_hit !== 1'b1 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk("hit", {31'd0, i_hit}, 32'd1);
        chk("instr", {16'd0, instr}, {16'd0, e});
    endtask

    task automatic fill(input logic [15:0] base);
        wait_re(base);
        feed(base, 8'h0F, 4, -1, 16'h0, -1);
        wait_hit(mem_word(base));
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        i_addr      = 16'h0010;
        inval       = 1'b0;
        mem_valid   = 1'b0;
        mem_rd_data = 16'h0000;

        // 1: reset state, cold miss, exact refill latency
        #12;
        chk("rst_hit", {31'd0, i_hit}, 32'd0);
        chk("rst_instr", {16'd0, instr}, 32'd0);
        chk("rst_re", {31'd0, mem_re}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_re", {31'd0, mem_re}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_re", {31'd0, mem_re}, 32'd1);
        chk("lat_addr", {16'd0, mem_addr}, 32'h0010);
        feed(16'h0010, 8'h0F, 4, -1, 16'h0, -1);
        @(negedge clk);
        #1;
        chk("lat_hit", {31'd0, i_hit}, 32'd1);
        wait_hit(mem_word(16'h0010));

        // 2: same line, consecutive hits
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            i_addr = 16'h0010 + 16'(k);
            sb.push_back(mem_word(i_addr));
            #1;
            chk("seq_hit", {31'd0, i_hit}, 32'd1);
            chk("seq_instr", {16'd0, instr}, {16'd0, sb.pop_front()});
            chk("seq_re", {31'd0, mem_re}, 32'd0);
        end

        // 3: conflict on index 4
        @(negedge clk);
        i_addr = 16'h0410;
        #1;
        chk("conf_miss", {31'd0, i_hit}, 32'd0);
        fill(16'h0410);
        @(negedge clk);
        i_addr = 16'h0010;
        #1;
        chk("conf_evict", {31'd0, i_hit}, 32'd0);
        fill(16'h0010);

        // 4: redirect mid-fill
        @(negedge clk);
        i_addr = 16'h0020;
        wait_re(16'h0020);
        feed(16'h0020, 8'h0F, 4, 1, 16'h0030, -1);
        fill(16'h0030);
        @(negedge clk);
        i_addr = 16'h0020;
        #1;
        chk("redir_valid", {31'd0, i_hit}, 32'd1);
        chk("redir_data", {16'd0, instr}, {16'd0, mem_word(16'h0020)});

        // 5: inval with last beat, mid-fill, and in IDLE
        @(negedge clk);
        i_addr = 16'h0060;
        wait_re(16'h0060);
        feed(16'h0060, 8'h0F, 4, -1, 16'h0, 3);
        fill(16'h0060);
        @(negedge clk);
        i_addr = 16'h0064;
        wait_re(16'h0064);
        feed(16'h0064, 8'h0F, 4, -1, 16'h0, 1);
        fill(16'h0064);
        @(negedge clk);
        i_addr = 16'h0060;
        #1;
        chk("mid_clear", {31'd0, i_hit}, 32'd0);
        fill(16'h0060);
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval  = 1'b0;
        i_addr = 16'h0010;
        #1;
        chk("idle_inval", {31'd0, i_hit}, 32'd0);
        fill(16'h0010);

        // 6: gapped beats, stray mem_valid, async reset mid-fill
        @(negedge clk);
        i_addr = 16'h0070;
        wait_re(16'h0070);
        feed(16'h0070, 8'h59, 7, -1, 16'h0, -1);
        wait_hit(mem_word(16'h0070));
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            i_addr = 16'h0070 + 16'(k);
            sb.push_back(mem_word(i_addr));
            #1;
            chk("gap_instr", {16'd0, instr}, {16'd0, sb.pop_front()});
        end
        @(negedge clk);
        i_addr      = 16'h0070;
        mem_valid   = 1'b1;
        mem_rd_data = 16'hFFFF;
        @(negedge clk);
        mem_valid = 1'b0;
        #1;
        chk("stray_ign", {16'd0, instr}, {16'd0, mem_word(16'h0070)});
        @(negedge clk);
        i_addr = 16'h0080;
        wait_re(16'h0080);
        @(negedge clk);
        mem_valid   = 1'b1;
        mem_rd_data = mem_word(16'h0080);
        @(negedge clk);
        mem_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_re", {31'd0, mem_re}, 32'd0);
        chk("arst_addr", {16'd0, mem_addr}, 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        i_addr = 16'h0010;
        #1;
        chk("arst_m10", {31'd0, i_hit}, 32'd0);
        i_addr = 16'h0070;
        #1;
        chk("arst_m70", {31'd0, i_hit}, 32'd0);
        i_addr = 16'h0080;
        #1;
        chk("arst_m80", {31'd0, i_hit}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
